// File: rtl/game_pkg.sv
// Shared definitions for the game controller and the round scorer:
// move and round-result encodings, combo width, controller state codes,
// latch state codes and the round scoring helpers.
package game_pkg;

    // Player move encoding as delivered by the input synchronisers
    typedef enum logic [1:0] {
        ROCK     = 2'd0,
        PAPER    = 2'd1,
        SCISSORS = 2'd2,
        NONE     = 2'd3
    } move_e;

    // Result of one round
    typedef enum logic [1:0] {
        TIE = 2'b00,
        P1  = 2'b01,
        P2  = 2'b10
    } winner_e;

    // One bit per (p1, p2) move pair
    localparam int COMBO_W = 9;

    // Controller state codes, kept here so controller and scorer agree
    typedef enum logic [2:0] {
        CTL_IDLE       = 3'd0,
        CTL_WAIT_MOVES = 3'd1,
        CTL_BRANCH     = 3'd2,
        CTL_RESOLVE    = 3'd3,
        CTL_CHECK      = 3'd4,
        CTL_MATCH_END  = 3'd5
    } ctl_state_e;

    // Per-player move latch state
    typedef enum logic {
        LATCH_UNLOCKED = 1'b0,
        LATCH_LOCKED   = 1'b1
    } latch_state_e;

    // Winner of a round: the move one step "ahead" modulo 3 wins
    function automatic logic [1:0] round_outcome(input logic [1:0] p1, input logic [1:0] p2);
        logic [1:0] res;
        res = TIE;
        case ({p1, p2})
            4'b0000, 4'b0101, 4'b1010: res = TIE;
            4'b0100, 4'b1001, 4'b0010: res = P1;
            default:                   res = P2;
        endcase
        return res;
    endfunction

    // One-hot move pair, bit index = p1*3 + p2
    function automatic logic [COMBO_W-1:0] combo_onehot(input logic [1:0] p1, input logic [1:0] p2);
        logic [3:0] idx;
        idx = ({2'b00, p1} << 1) + {2'b00, p1} + {2'b00, p2};
        return 9'b000000001 << idx;
    endfunction

endpackage

// File: rtl/round_scorer_choice_latch.sv
// choice_latch: one player's move latch. Unlocked until a valid, non-NONE
// strobe arrives; the move is then frozen until an unlock command.
// Unlock always wins over a strobe in the same cycle.
module choice_latch
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_valid,
    input  logic [1:0] i_choice,
    input  logic       i_unlock,
    output logic       o_locked,
    output logic [1:0] o_choice
);

    latch_state_e r_state;
    latch_state_e w_state_nxt;
    logic [1:0]   r_move;
    logic [1:0]   w_move_nxt;

    // Latch state and stored move registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= LATCH_UNLOCKED;
            r_move  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_move  <= w_move_nxt;
        end
    end

    // Next state: unlock first, otherwise accept one real move while unlocked
    always_comb begin
        w_state_nxt = r_state;
        w_move_nxt  = r_move;
        case (r_state)
            LATCH_UNLOCKED: begin
                if (i_unlock) begin
                    w_state_nxt = LATCH_UNLOCKED;
                end else if (i_valid && (i_choice != NONE)) begin
                    w_state_nxt = LATCH_LOCKED;
                    w_move_nxt  = i_choice;
                end else begin
                    w_state_nxt = LATCH_UNLOCKED;
                end
            end
            LATCH_LOCKED: begin
                if (i_unlock) begin
                    w_state_nxt = LATCH_UNLOCKED;
                end else begin
                    w_state_nxt = LATCH_LOCKED;
                end
            end
            default: begin
                w_state_nxt = LATCH_UNLOCKED;
            end
        endcase
    end

    assign o_locked = (r_state == LATCH_LOCKED);
    assign o_choice = r_move;

endmodule

// File: rtl/round_scorer.sv
// round_scorer: latches both players' moves, reports the move pair as a
// one-hot combo, scores rounds on resolve rising edges and flags match end.
// Commands (resolve, clearScores, clearChoices) are registered first and
// acted on one edge later; move strobes are taken directly.
// Optional build macro: ROUND_SCORER_STATS_EN adds the 8-bit tieCount output.
module round_scorer
    import game_pkg::*;
#(
    parameter int WIN_SCORE = 3,
    parameter int SCORE_W   = 2
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               p1Valid,
    input  logic [1:0]         p1Choice,
    input  logic               p2Valid,
    input  logic [1:0]         p2Choice,
    input  logic               clearScores,
    input  logic               clearChoices,
    input  logic               resolve,
    output logic               bothLocked,
    output logic [COMBO_W-1:0] combo,
    output logic               roundDone,
    output logic [1:0]         roundWinner,
    output logic [SCORE_W-1:0] p1Score,
    output logic [SCORE_W-1:0] p2Score,
    output logic               matchOver,
    output logic               p1Wins
`ifdef ROUND_SCORER_STATS_EN
    ,
    output logic [7:0]         tieCount
`endif
);

    localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

    // Latch outputs
    logic               w_p1_locked;
    logic               w_p2_locked;
    logic [1:0]         w_p1_move;
    logic [1:0]         w_p2_move;

    // Registered commands
    logic               r_resolve_q1;
    logic               r_resolve_q2;
    logic               r_clear_scores_q;
    logic               r_clear_choices_q;

    // Decoded actions for this cycle
    logic               w_resolve_rise;
    logic               w_score_round;
    logic               w_unlock;
    logic [1:0]         w_outcome;

    // Output state
    logic               r_both_locked;
    logic [COMBO_W-1:0] r_combo;
    logic               r_round_done;
    logic [1:0]         r_round_winner;
    logic [SCORE_W-1:0] r_p1_score;
    logic [SCORE_W-1:0] r_p2_score;
    logic               r_match_over;
    logic               r_p1_wins;

    logic               w_both_locked_nxt;
    logic [COMBO_W-1:0] w_combo_nxt;
    logic               w_round_done_nxt;
    logic [1:0]         w_round_winner_nxt;
    logic [SCORE_W-1:0] w_p1_score_nxt;
    logic [SCORE_W-1:0] w_p2_score_nxt;
    logic               w_match_over_nxt;
    logic               w_p1_wins_nxt;

    choice_latch u_p1_latch (
        .clk      (clk),
        .reset    (reset),
        .i_valid  (p1Valid),
        .i_choice (p1Choice),
        .i_unlock (w_unlock),
        .o_locked (w_p1_locked),
        .o_choice (w_p1_move)
    );

    choice_latch u_p2_latch (
        .clk      (clk),
        .reset    (reset),
        .i_valid  (p2Valid),
        .i_choice (p2Choice),
        .i_unlock (w_unlock),
        .o_locked (w_p2_locked),
        .o_choice (w_p2_move)
    );

    // Command sampling; resolve history resets high so a held resolve is not an edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_resolve_q1      <= 1'b1;
            r_resolve_q2      <= 1'b1;
            r_clear_scores_q  <= 1'b0;
            r_clear_choices_q <= 1'b0;
        end else begin
            r_resolve_q1      <= resolve;
            r_resolve_q2      <= r_resolve_q1;
            r_clear_scores_q  <= clearScores;
            r_clear_choices_q <= clearChoices;
        end
    end

    // A resolve only counts with both moves in and the match still open; clearScores overrides it
    assign w_resolve_rise = r_resolve_q1 & ~r_resolve_q2;
    assign w_score_round  = w_resolve_rise & r_both_locked & ~r_match_over & ~r_clear_scores_q;
    assign w_unlock       = r_clear_scores_q | w_score_round | r_clear_choices_q;
    assign w_outcome      = round_outcome(w_p1_move, w_p2_move);

    // Pair status: cleared by any unlock, otherwise follows the latch states
    always_comb begin
        w_both_locked_nxt = 1'b0;
        w_combo_nxt       = '0;
        if (w_unlock) begin
            w_both_locked_nxt = 1'b0;
            w_combo_nxt       = '0;
        end else if (w_p1_locked && w_p2_locked) begin
            w_both_locked_nxt = 1'b1;
            w_combo_nxt       = combo_onehot(w_p1_move, w_p2_move);
        end else begin
            w_both_locked_nxt = 1'b0;
            w_combo_nxt       = '0;
        end
    end

    // Scoring: new match clears everything, an effective resolve scores the round
    always_comb begin
        w_round_done_nxt   = 1'b0;
        w_round_winner_nxt = r_round_winner;
        w_p1_score_nxt     = r_p1_score;
        w_p2_score_nxt     = r_p2_score;
        w_match_over_nxt   = r_match_over;
        w_p1_wins_nxt      = r_p1_wins;
        if (r_clear_scores_q) begin
            w_round_winner_nxt = TIE;
            w_p1_score_nxt     = '0;
            w_p2_score_nxt     = '0;
            w_match_over_nxt   = 1'b0;
            w_p1_wins_nxt      = 1'b0;
        end else if (w_score_round) begin
            w_round_done_nxt   = 1'b1;
            w_round_winner_nxt = w_outcome;
            case (w_outcome)
                P1: begin
                    if (r_p1_score < WIN_S) begin
                        w_p1_score_nxt = r_p1_score + SCORE_ONE;
                    end else begin
                        w_p1_score_nxt = WIN_S;
                    end
                end
                P2: begin
                    if (r_p2_score < WIN_S) begin
                        w_p2_score_nxt = r_p2_score + SCORE_ONE;
                    end else begin
                        w_p2_score_nxt = WIN_S;
                    end
                end
                default: begin
                    w_p1_score_nxt = r_p1_score;
                    w_p2_score_nxt = r_p2_score;
                end
            endcase
            w_match_over_nxt = r_match_over | (w_p1_score_nxt == WIN_S) | (w_p2_score_nxt == WIN_S);
            w_p1_wins_nxt    = (w_p1_score_nxt == WIN_S);
        end else begin
            w_round_winner_nxt = r_round_winner;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_both_locked  <= 1'b0;
            r_combo        <= '0;
            r_round_done   <= 1'b0;
            r_round_winner <= 2'b00;
            r_p1_score     <= '0;
            r_p2_score     <= '0;
            r_match_over   <= 1'b0;
            r_p1_wins      <= 1'b0;
        end else begin
            r_both_locked  <= w_both_locked_nxt;
            r_combo        <= w_combo_nxt;
            r_round_done   <= w_round_done_nxt;
            r_round_winner <= w_round_winner_nxt;
            r_p1_score     <= w_p1_score_nxt;
            r_p2_score     <= w_p2_score_nxt;
            r_match_over   <= w_match_over_nxt;
            r_p1_wins      <= w_p1_wins_nxt;
        end
    end

    assign bothLocked  = r_both_locked;
    assign combo       = r_combo;
    assign roundDone   = r_round_done;
    assign roundWinner = r_round_winner;
    assign p1Score     = r_p1_score;
    assign p2Score     = r_p2_score;
    assign matchOver   = r_match_over;
    assign p1Wins      = r_p1_wins;

`ifdef ROUND_SCORER_STATS_EN
    logic [7:0] r_tie_count;

    // Saturating count of scored ties, updated alongside roundWinner
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tie_count <= 8'd0;
        end else if (r_clear_scores_q) begin
            r_tie_count <= 8'd0;
        end else if (w_score_round && (w_outcome == TIE) && (r_tie_count != 8'hFF)) begin
            r_tie_count <= r_tie_count + 8'd1;
        end else begin
            r_tie_count <= r_tie_count;
        end
    end

    assign tieCount = r_tie_count;
`endif

endmodule

// File: tb/tb_round_scorer.sv
// Scoreboard bench for round_scorer: expected round results are pushed when
// a scoring resolve is driven and popped when roundDone is seen.
module tb_round_scorer;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       p1Valid;
    logic [1:0] p1Choice;
    logic       p2Valid;
    logic [1:0] p2Choice;
    logic       clearScores;
    logic       clearChoices;
    logic       resolve;
    logic       bothLocked;
    logic [8:0] combo;
    logic       roundDone;
    logic [1:0] roundWinner;
    logic [1:0] p1Score;
    logic [1:0] p2Score;
    logic       matchOver;
    logic       p1Wins;
`ifdef ROUND_SCORER_STATS_EN
    logic [7:0] tieCount;
`endif

    round_scorer #(.WIN_SCORE(3), .SCORE_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .p1Valid      (p1Valid),
        .p1Choice     (p1Choice),
        .p2Valid      (p2Valid),
        .p2Choice     (p2Choice),
        .clearScores  (clearScores),
        .clearChoices (clearChoices),
        .resolve      (resolve),
        .bothLocked   (bothLocked),
        .combo        (combo),
        .roundDone    (roundDone),
        .roundWinner  (roundWinner),
        .p1Score      (p1Score),
        .p2Score      (p2Score),
        .matchOver    (matchOver),
        .p1Wins       (p1Wins)
`ifdef ROUND_SCORER_STATS_EN
        ,
        .tieCount     (tieCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] win;
        logic [1:0] s1;
        logic [1:0] s2;
        logic       mo;
        logic       pw;
        logic [7:0] tie;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    int   m_s1, m_s2, m_tie;
    logic m_mo;
    logic prev_rd = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_winner(input int a, input int b);
        int d;
        d = (a - b + 3) % 3;
        if (d == 0) return 2'b00;
        else if (d == 1) return 2'b01;
        else return 2'b10;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_score(input int a, input int b);
        exp_t x;
        logic [1:0] w;
        w = ref_winner(a, b);
        if (w == 2'b01 && m_s1 < 3) m_s1++;
        if (w == 2'b10 && m_s2 < 3) m_s2++;
        if (w == 2'b00 && m_tie < 255) m_tie++;
        if (m_s1 == 3 || m_s2 == 3) m_mo = 1'b1;
        x.win = w;
        x.s1  = 2'(m_s1);
        x.s2  = 2'(m_s2);
        x.mo  = m_mo;
        x.pw  = (m_s1 == 3);
        x.tie = 8'(m_tie);
        sb.push_back(x);
    endtask

    task automatic model_clear();
        m_s1 = 0; m_s2 = 0; m_tie = 0; m_mo = 1'b0;
    endtask

    task automatic lock_both(input int a, input int b);
        p1Valid = 1'b1; p1Choice = 2'(a);
        p2Valid = 1'b1; p2Choice = 2'(b);
        tick();
        p1Valid = 1'b0; p2Valid = 1'b0;
        tick();
    endtask

    task automatic resolve_round(input int a, input int b);
        logic eff;
        eff = !m_mo;
        if (eff) model_score(a, b);
        resolve = 1'b1;
        tick();
        resolve = 1'b0;
        tick();
        if (eff) begin
            chk("combo_after_resolve", combo, 0);
            chk("both_after_resolve", bothLocked, 0);
        end else begin
            chk("both_kept_match_over", bothLocked, 1);
        end
        chk("p1Score", p1Score, m_s1);
        chk("p2Score", p2Score, m_s2);
        tick();
    endtask

    task automatic pulse_clear(input logic scores);
        if (scores) clearScores = 1'b1; else clearChoices = 1'b1;
        tick();
        clearScores = 1'b0; clearChoices = 1'b0;
        tick();
    endtask

    // Scoreboard monitor: every roundDone must match the oldest expected round
    always @(negedge clk) begin
        if (reset) begin
            if (roundDone && prev_rd) chk("roundDone_width", 1, 0);
            if (roundDone) begin
                if (sb.size() == 0) begin
                    chk("roundDone_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("roundWinner", roundWinner, e.win);
                    chk("sb_p1Score", p1Score, e.s1);
                    chk("sb_p2Score", p2Score, e.s2);
                    chk("sb_matchOver", matchOver, e.mo);
                    chk("sb_p1Wins", p1Wins, e.pw);
`ifdef ROUND_SCORER_STATS_EN
                    chk("sb_tieCount", tieCount, e.tie);
`endif
                end
            end
            prev_rd <= roundDone;
        end else begin
            prev_rd <= 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; p1Valid = 1'b0; p1Choice = 2'd0; p2Valid = 1'b0; p2Choice = 2'd0;
        clearScores = 1'b0; clearChoices = 1'b0; resolve = 1'b1;
        model_clear();
        tick(); tick();
        chk("rst_combo", combo, 0);
        chk("rst_both", bothLocked, 0);
        chk("rst_scores", {p1Score, p2Score}, 0);
        chk("rst_match", {matchOver, p1Wins, roundDone, roundWinner}, 0);
        reset = 1'b1;
        tick(); tick();
        resolve = 1'b0;
        tick();

        // Lock order and frozen moves
        p1Valid = 1'b1; p1Choice = 2'd1; tick(); p1Valid = 1'b0;
        p2Valid = 1'b1; p2Choice = 2'd0; tick(); p2Valid = 1'b0;
        chk("combo_not_yet", combo, 0);
        tick();
        chk("combo_lock", combo, 9'b000001000);
        chk("both_lock", bothLocked, 1);
        p1Valid = 1'b1; p1Choice = 2'd2; tick(); p1Valid = 1'b0; tick();
        chk("combo_frozen", combo, 9'b000001000);
        resolve_round(1, 0);

        // Tie
        lock_both(0, 0);
        resolve_round(0, 0);
`ifdef ROUND_SCORER_STATS_EN
        chk("tie_count_1", tieCount, 1);
`endif

        // Resolve held high scores once
        lock_both(0, 1);
        model_score(0, 1);
        resolve = 1'b1;
        repeat (10) tick();
        resolve = 1'b0;
        tick();
        chk("held_p2Score", p2Score, m_s2);
        chk("held_p1Score", p1Score, m_s1);

        // Resolve with only p1 locked does nothing; p1 stays locked
        p1Valid = 1'b1; p1Choice = 2'd2; tick(); p1Valid = 1'b0; tick();
        resolve = 1'b1; tick(); resolve = 1'b0; tick(); tick();
        chk("half_both", bothLocked, 0);
        p2Valid = 1'b1; p2Choice = 2'd0; tick(); p2Valid = 1'b0; tick();
        chk("half_combo", combo, 9'b001000000);
        clearChoices = 1'b1; tick(); clearChoices = 1'b0;
        chk("cc_not_yet", bothLocked, 1);
        tick();
        chk("cc_both", bothLocked, 0);
        chk("cc_combo", combo, 0);

        // Strobe together with clearChoices is lost; NONE never locks
        p1Valid = 1'b1; p1Choice = 2'd1; tick(); p1Valid = 1'b0;
        clearChoices = 1'b1; p2Valid = 1'b1; p2Choice = 2'd2; tick();
        clearChoices = 1'b0; p2Valid = 1'b0; tick(); tick();
        chk("cc_strobe_both", bothLocked, 0);
        p1Valid = 1'b1; p1Choice = 2'd1; tick(); p1Valid = 1'b0; tick(); tick();
        chk("p2_unlocked", bothLocked, 0);
        p2Valid = 1'b1; p2Choice = 2'd3; tick(); p2Valid = 1'b0; tick(); tick();
        chk("none_ignored", bothLocked, 0);
        pulse_clear(1'b0);

        // Player 2 takes the match, then resolves are ignored
        lock_both(0, 1); resolve_round(0, 1);
        lock_both(0, 1); resolve_round(0, 1);
        chk("p2_match_over", matchOver, 1);
        chk("p2_match_p1Wins", p1Wins, 0);
        lock_both(0, 1); resolve_round(0, 1);

        // New match
        clearScores = 1'b1; tick(); clearScores = 1'b0;
        chk("cs_not_yet", matchOver, 1);
        tick();
        model_clear();
        chk("cs_scores", {p1Score, p2Score}, 0);
        chk("cs_match", {matchOver, p1Wins, roundWinner}, 0);
        chk("cs_both", bothLocked, 0);
`ifdef ROUND_SCORER_STATS_EN
        chk("cs_tie", tieCount, 0);
`endif

        // Player 1 takes the match via every winning pair
        lock_both(2, 0); resolve_round(2, 0);
        lock_both(1, 0); resolve_round(1, 0);
        lock_both(2, 1); resolve_round(2, 1);
        lock_both(0, 2); resolve_round(0, 2);
        chk("p1_match_p1Wins", p1Wins, 1);
        pulse_clear(1'b1);
        model_clear();

        // Asynchronous reset mid-match
        lock_both(1, 0); resolve_round(1, 0);
        lock_both(1, 0); resolve_round(1, 0);
        chk("pre_reset_p1Score", p1Score, 2);
        p1Valid = 1'b1; p1Choice = 2'd0; tick(); p1Valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_scores", {p1Score, p2Score}, 0);
        chk("async_rst_win", roundWinner, 0);
        model_clear();
        #1;
        reset = 1'b1;
        tick();
        p2Valid = 1'b1; p2Choice = 2'd1; tick(); p2Valid = 1'b0; tick(); tick();
        chk("rst_lost_p1_lock", bothLocked, 0);

        tick();
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
